// File: rtl/weight_sweep_ctrl.sv
// Clause-weight sequencer: loads NBEATS weight beats into the adder bank, then sweeps clause_no and
// accumulates the clause-gated signed weights into the class sum. Optional feature macro: WEIGHT_REUSE_EN.
module weight_sweep_ctrl #(
  parameter int unsigned CLAUSEN = 10,
  parameter int unsigned NBEATS  = 5,
  parameter int unsigned SUMW    = 9 + $clog2(CLAUSEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef WEIGHT_REUSE_EN
  input  logic                     reuse,
`endif
  input  logic [$clog2(CLAUSEN):0] clauses,
  input  logic [CLAUSEN-1:0]       clause_out,
  input  logic [255:0]             wbeat_data,
  input  logic                     wbeat_valid,
  output logic                     wbeat_ready,
  output logic                     wa_valid,
  output logic [255:0]             wa_weight_write,
  output logic [2:0]               wa_offset,
  output logic [$clog2(CLAUSEN):0] wa_clauses,
  output logic [$clog2(CLAUSEN):0] wa_clause_no,
  input  logic signed [8:0]        wa_weight,
  output logic                     busy,
  output logic signed [SUMW-1:0]   sum,
  output logic                     sum_valid
);

  localparam int unsigned IW = $clog2(CLAUSEN);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned OW = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SWEEP = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          clauses_q, clauses_d;
  logic [CLAUSEN-1:0]     clause_out_q, clause_out_d;
  logic [OW-1:0]          offset_q, offset_d;
  logic [CW-1:0]          clause_no_q, clause_no_d;
  logic [1:0]             vld_q, vld_d;
  logic [IW-1:0]          tag0_q, tag0_d;
  logic [IW-1:0]          tag1_q, tag1_d;
  logic signed [SUMW-1:0] sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic                   beat_hs;
  logic                   take_reuse;

  assign beat_hs = wbeat_valid & ready_q;

`ifdef WEIGHT_REUSE_EN
  assign take_reuse = reuse;
`else
  assign take_reuse = 1'b0;
`endif

  // Next-state, counters, read-tag pipe and accumulator
  always_comb begin
    state_d      = state_q;
    clauses_d    = clauses_q;
    clause_out_d = clause_out_q;
    offset_d     = offset_q;
    clause_no_d  = clause_no_q;
    vld_d        = {vld_q[0], 1'b0};
    tag0_d       = tag0_q;
    tag1_d       = tag0_q;
    sum_d        = sum_q;

    // Weight read returns two cycles after issue; the tag selects its clause_out bit.
    if (vld_q[1] && clause_out_q[tag1_q]) begin
      sum_d = sum_q + SUMW'(wa_weight);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clauses_d    = (clauses > CW'(CLAUSEN)) ? CW'(CLAUSEN) : clauses;
          clause_out_d = clause_out;
          sum_d        = '0;
          offset_d     = '0;
          clause_no_d  = '0;
          state_d      = take_reuse ? S_SWEEP : S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat_hs) begin
          if (offset_q == OW'(NBEATS - 1)) begin
            state_d = S_SWEEP;
          end else begin
            offset_d = offset_q + OW'(1);
          end
        end
      end
      S_SWEEP: begin
        if (clauses_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          vld_d[0] = 1'b1;
          tag0_d   = clause_no_q[IW-1:0];
          if (clause_no_q == clauses_q - CW'(1)) begin
            state_d = S_DRAIN;
          end else begin
            clause_no_d = clause_no_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Stage 0 empty means the last read is accumulated this cycle.
        if (!vld_q[0]) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sum_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    ready_d     = (state_d == S_LOAD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clauses_q    <= '0;
      clause_out_q <= '0;
      offset_q     <= '0;
      clause_no_q  <= '0;
      vld_q        <= '0;
      tag0_q       <= '0;
      tag1_q       <= '0;
      sum_q        <= '0;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clauses_q    <= clauses_d;
      clause_out_q <= clause_out_d;
      offset_q     <= offset_d;
      clause_no_q  <= clause_no_d;
      vld_q        <= vld_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
      sum_q        <= sum_d;
      sum_valid_q  <= sum_valid_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign wbeat_ready     = ready_q;
  assign wa_valid        = beat_hs;
  assign wa_weight_write = wbeat_data;
  assign wa_offset       = offset_q;
  assign wa_clauses      = clauses_q;
  assign wa_clause_no    = clause_no_q;
  assign busy            = busy_q;
  assign sum             = sum_q;
  assign sum_valid       = sum_valid_q;

endmodule

// File: doc/weight_sweep_ctrl.md
# weight_sweep_ctrl

Sequencer for the clause weight adder. It streams five 256-bit weight beats into the adder's weight register bank, then sweeps `clause_no` across all active clauses. Each returned 9-bit signed weight is gated by the matching clause output bit and accumulated into a signed class sum. It sits between the weight memory stream and the class-sum/argmax stage, one instance per class.

## Interface
- `CLAUSEN`, 10: number of clauses; the weight bank holds `CLAUSEN` 9-bit weights.
- `NBEATS`, 5: 256-bit beats per weight load; offsets run 0..`NBEATS`-1.
- `SUMW`, 9+$clog2(`CLAUSEN`): width of the signed class sum.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load+sweep; ignored unless in IDLE.
- `clauses`  in  $clog2(CLAUSEN)+1  active clause count; sampled on accepted `start`.
- `clause_out`  in  CLAUSEN  clause output bitmap; sampled on accepted `start`.
- `wbeat_data`  in  256  weight beat.
- `wbeat_valid`  in  1  beat valid.
- `wbeat_ready`  out  1  beat accepted when high with `wbeat_valid`.
- `wa_valid`  out  1  adder write strobe.
- `wa_weight_write`  out  256  adder write data.
- `wa_offset`  out  3  adder beat offset.
- `wa_clauses`  out  $clog2(CLAUSEN)+1  latched clause count.
- `wa_clause_no`  out  $clog2(CLAUSEN)+1  clause index being read.
- `wa_weight`  in  9 signed  adder read data; valid 2 cycles after `wa_clause_no`.
- `busy`  out  1  high in every state except IDLE.
- `sum`  out  SUMW signed  class sum; holds until the next accepted `start`.
- `sum_valid`  out  1  one-cycle pulse when `sum` is final.

## Operation
- States: IDLE → LOAD → SWEEP → DRAIN → DONE → IDLE.
- IDLE, on `start`:
  - latch `clauses`; clamp any value above CLAUSEN to CLAUSEN.
  - latch `clause_out`.
  - clear `sum` and the beat and clause counters.
  - go to LOAD.
- LOAD:
  - `wbeat_ready`=1.
  - `wa_valid` = `wbeat_valid` & `wbeat_ready`, combinational.
  - `wa_weight_write` = `wbeat_data` passthrough.
  - `wa_offset` = beat counter; it advances on each handshake.
  - The handshake with counter = NBEATS-1 moves the FSM to SWEEP.
  - Stalls (`wbeat_valid`=0) are held indefinitely.
- SWEEP:
  - `wa_clause_no` = clause counter k, registered, advancing 0..N-1 at one per cycle.
  - A 2-bit valid shift register tags each issue with its k.
  - After k=N-1 is issued, go to DRAIN.
  - N=0: go straight to DRAIN with nothing issued.
- DRAIN: continues accumulating until the valid pipe is empty (2 cycles), then goes to DONE.
- Accumulate: when the tagged valid emerges, `sum` += sign-extended `wa_weight` if `clause_out[k]`=1, else `sum` += 0. `SUMW` cannot overflow.
- DONE: `sum_valid`=1 for one cycle, then return to IDLE.
- Outputs outside their active state: `wbeat_ready`=0 and `wa_valid`=0. `wa_offset`, `wa_clause_no` and `wa_clauses` hold their last values.
- `rst` mid-operation returns to IDLE immediately and discards the partial sum. The adder shares `rst`, so its bank is cleared too.

## Timing
- Reset values: `wbeat_ready`=0, `wa_valid`=0, `wa_offset`=0, `wa_clauses`=0, `wa_clause_no`=0, `busy`=0, `sum`=0, `sum_valid`=0.
- `start` sampled at cycle 0 → LOAD in cycle 1.
- Back-to-back beats handshake in cycles 1..5; the adder writes at the end of cycle 5.
- `wa_clause_no`=k is driven in cycle 6+k. The weight arrives in cycle 8+k and is accumulated at the end of that cycle.
- `sum_valid` is asserted in cycle N+8; `busy` falls in cycle N+9.
- Each stall cycle in LOAD adds one cycle.

## Configuration
- `WEIGHT_REUSE_EN` defined:
  - adds input `reuse` (1 bit), sampled with `start`.
  - `start` & `reuse` skips LOAD and enters SWEEP at cycle 1 using the already-loaded bank; `sum_valid` is then at cycle N+3.
- `WEIGHT_REUSE_EN` undefined: the `reuse` port is absent and every `start` performs LOAD.

## Test plan
- Beats carrying weights +1..+10 (clause_no k maps to slice `clauses`-1-k), `clause_out`=all-ones, N=10, no stalls → `sum`=55, `sum_valid` at cycle 18, exactly 5 `wa_valid` pulses with offsets 0..4.
- Same weights, `clause_out`=10'b0101010101 → `sum` is the sum of selected weights only. Alternate weights to -256 and +255 → correct signed result (negative case).
- `wbeat_valid` toggled every other cycle during LOAD → offsets stay contiguous and `sum_valid` is delayed by exactly the stall count.
- `clauses`=0 → no SWEEP issues, `sum`=0, `sum_valid` at cycle 8. `clauses`=15 → clamped to 10.
- `start` pulsed while `busy` → ignored. `rst` asserted in SWEEP → next cycle `busy`=0, `sum`=0, no `sum_valid`.
- `WEIGHT_REUSE_EN` defined: second `start` with `reuse`=1 → no `wbeat_ready`, same sum as the first run, `sum_valid` at cycle N+3.
